// File: rtl/bk_sram_arbiter.sv
// Single-port SRAM arbiter: reserved slot-0 video fetch, then CPU (priority) and host
// one-cycle accesses with level reply/ack handshakes.
`timescale 1ns/1ps
module bk_sram_arbiter #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16,
    parameter logic [4:0]  VBASE  = 5'b00001
) (
    input  logic              clk25,
    input  logic              reset_n,
    input  logic [3:0]        slot,
    input  logic [12:0]       vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              cpu_rd,
    input  logic              cpu_wt,
    input  logic              cpu_byte,
    input  logic [15:0]       cpu_adr,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_reply,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_dout,
    output logic [DATA_W-1:0] host_din,
    output logic              host_ack,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_dq,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n
);

    localparam int unsigned SLOT_W = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CPU_ACC   = 3'd1,
        CPU_DONE  = 3'd2,
        HOST_ACC  = 3'd3,
        HOST_DONE = 3'd4
    } state_t;

    state_t              state, state_nx;
    logic                cpu_req, cpu_req_q, cpu_pend, cpu_rise, cpu_want;
    logic                host_pend, cpu_start;
    logic                video_slot, last_slot;
    logic                dq_oe;
    logic [DATA_W-1:0]   dq_out;

    assign cpu_req    = cpu_rd | cpu_wt;
    assign cpu_rise   = cpu_req & ~cpu_req_q;
    // A fresh edge counts immediately so a simultaneous host request loses to the CPU.
    assign cpu_want   = cpu_req & (cpu_pend | cpu_rise);
    assign host_pend  = host_req & ~host_ack;
    assign video_slot = (slot == SLOT_W'(0));
    assign last_slot  = (slot == SLOT_W'(15));

    assign ram_dq = dq_oe ? dq_out : {DATA_W{1'bz}};

    // State register and handshake/data latches.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cpu_req_q <= 1'b0;
            cpu_pend  <= 1'b0;
            cpu_reply <= 1'b0;
            host_ack  <= 1'b0;
            cpu_din   <= '0;
            host_din  <= '0;
            vga_data  <= '0;
            vga_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cpu_req_q <= cpu_req;
            cpu_pend  <= cpu_want & ~cpu_start;
            cpu_reply <= (state_nx == CPU_DONE);
            host_ack  <= (state_nx == HOST_DONE);
            vga_valid <= video_slot;
            if (video_slot) begin
                vga_data <= ram_dq;
            end
            if (state == CPU_ACC && !cpu_wt) begin
                cpu_din <= ram_dq;
            end
            if (state == HOST_ACC && !host_we) begin
                host_din <= ram_dq;
            end
        end
    end

    // Next state and SRAM pin drive; slot 0 always belongs to the video fetch.
    always_comb begin
        state_nx  = state;
        cpu_start = 1'b0;
        ram_addr  = '0;
        ram_oe_n  = 1'b1;
        ram_we_n  = 1'b1;
        ram_lb_n  = 1'b1;
        ram_ub_n  = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;

        case (state)
            IDLE: begin
                if (!last_slot) begin
                    if (cpu_want) begin
                        state_nx  = CPU_ACC;
                        cpu_start = 1'b1;
                    end else if (host_pend) begin
                        state_nx = HOST_ACC;
                    end
                end
            end
            CPU_ACC:   state_nx = CPU_DONE;
            CPU_DONE:  if (!cpu_req) state_nx = IDLE;
            HOST_ACC:  state_nx = HOST_DONE;
            HOST_DONE: if (!host_req) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase

        if (video_slot) begin
            ram_addr = ADDR_W'({VBASE, vga_addr});
            ram_oe_n = 1'b0;
            ram_lb_n = 1'b0;
            ram_ub_n = 1'b0;
        end else if (state == CPU_ACC) begin
            ram_addr = ADDR_W'(cpu_adr[15:1]);
            ram_lb_n = cpu_byte & cpu_adr[0];
            ram_ub_n = cpu_byte & ~cpu_adr[0];
            if (cpu_wt) begin
                ram_we_n = 1'b0;
                dq_oe    = 1'b1;
                dq_out   = cpu_dout;
            end else begin
                ram_oe_n = 1'b0;
            end
        end else if (state == HOST_ACC) begin
            ram_addr = host_addr;
            ram_lb_n = 1'b0;
            ram_ub_n = 1'b0;
            if (host_we) begin
                ram_we_n = 1'b0;
                dq_oe    = 1'b1;
                dq_out   = host_dout;
            end else begin
                ram_oe_n = 1'b0;
            end
        end
    end

endmodule
